// File: rtl/sum_accumulator.sv
// Accumulates N_OPS 5-bit adder results {Cout,S} into an 8-bit running total.
// Define SUM_ACCUMULATOR_SATURATE_EN to clamp at 255 instead of wrapping.
module sum_accumulator #(
    parameter int N_OPS = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       valid_in,
    input  logic [3:0] S,
    input  logic       Cout,
    input  logic       clear,
    output logic       ready_out,
    output logic [7:0] acc,
    output logic [3:0] count,
    output logic       overflow,
    output logic       done
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        HOLD
    } state_t;

    localparam logic [3:0] LAST_COUNT = 4'(N_OPS);

    state_t     state_q;
    logic [7:0] acc_q;
    logic [7:0] acc_d;
    logic [3:0] count_q;
    logic [3:0] count_d;
    logic       overflow_q;
    logic       overflow_d;
    logic       done_q;
    logic [4:0] operand;
    logic [8:0] sum;
    logic       transfer;
    logic       batchFull;

    // Next-state values assuming a transfer happens; the FSM decides whether to take them.
    always_comb begin
        operand  = {Cout, S};
        sum      = {1'b0, acc_q} + {4'b0000, operand};
        transfer = valid_in && (state_q != HOLD);
        acc_d      = acc_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        if (state_q == IDLE) begin
            acc_d      = {3'b000, operand};
            count_d    = 4'd1;
            overflow_d = 1'b0;
        end else begin
            count_d    = count_q + 4'd1;
            overflow_d = overflow_q | sum[8];
`ifdef SUM_ACCUMULATOR_SATURATE_EN
            acc_d      = sum[8] ? 8'hFF : sum[7:0];
`else
            acc_d      = sum[7:0];
`endif
        end
        batchFull = (count_d == LAST_COUNT);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            acc_q      <= 8'd0;
            count_q    <= 4'd0;
            overflow_q <= 1'b0;
            done_q     <= 1'b0;
        end else if (clear) begin
            state_q    <= IDLE;
            acc_q      <= 8'd0;
            count_q    <= 4'd0;
            overflow_q <= 1'b0;
            done_q     <= 1'b0;
        end else if (transfer) begin
            acc_q      <= acc_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            done_q     <= batchFull;
            state_q    <= batchFull ? HOLD : RUN;
        end
    end

    // ready_out depends on state alone so upstream never sees a valid_in loop.
    assign ready_out = (state_q != HOLD);
    assign acc       = acc_q;
    assign count     = count_q;
    assign overflow  = overflow_q;
    assign done      = done_q;

endmodule

// File: tb/tb_sum_accumulator.sv
// Directed bench for sum_accumulator: three instances (N_OPS 4, 8, 9) share one stimulus stream.
module tb_sum_accumulator;

    logic       clk;
    logic       reset;
    logic       valid_in;
    logic [3:0] S;
    logic       Cout;
    logic       clear;

    logic       ready4, ovf4, done4;
    logic [7:0] acc4;
    logic [3:0] cnt4;
    logic       ready8, ovf8, done8;
    logic [7:0] acc8;
    logic [3:0] cnt8;
    logic       ready9, ovf9, done9;
    logic [7:0] acc9;
    logic [3:0] cnt9;

    int checks = 0;
    int errors = 0;

`ifdef SUM_ACCUMULATOR_SATURATE_EN
    localparam int EXP_ACC9 = 255;
`else
    localparam int EXP_ACC9 = 23;
`endif

    sum_accumulator #(.N_OPS(4)) dut4 (
        .clk(clk), .reset(reset), .valid_in(valid_in), .S(S), .Cout(Cout), .clear(clear),
        .ready_out(ready4), .acc(acc4), .count(cnt4), .overflow(ovf4), .done(done4)
    );

    sum_accumulator #(.N_OPS(8)) dut8 (
        .clk(clk), .reset(reset), .valid_in(valid_in), .S(S), .Cout(Cout), .clear(clear),
        .ready_out(ready8), .acc(acc8), .count(cnt8), .overflow(ovf8), .done(done8)
    );

    sum_accumulator #(.N_OPS(9)) dut9 (
        .clk(clk), .reset(reset), .valid_in(valid_in), .S(S), .Cout(Cout), .clear(clear),
        .ready_out(ready9), .acc(acc9), .count(cnt9), .overflow(ovf9), .done(done9)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle of inputs, then land 1 ns after the active edge for sampling.
    task automatic applyStimulus(input logic v, input logic [4:0] op, input logic clr);
        valid_in = v;
        Cout     = op[4];
        S        = op[3:0];
        clear    = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [8:0] obs, input logic [8:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    initial begin
        reset    = 1'b1;
        valid_in = 1'b0;
        S        = 4'h0;
        Cout     = 1'b0;
        clear    = 1'b0;
        #2;
        checkOutput("rst_acc", 9'(acc4), 9'd0);
        checkOutput("rst_count", 9'(cnt4), 9'd0);
        checkOutput("rst_ovf", 9'(ovf4), 9'd0);
        checkOutput("rst_done", 9'(done4), 9'd0);
        checkOutput("rst_ready", 9'(ready4), 9'd1);
        applyStimulus(1'b1, 5'd9, 1'b0);
        checkOutput("rst_holds_acc", 9'(acc4), 9'd0);
        reset = 1'b0;

        // Basic batch of four: 3, 7, 15, 16
        applyStimulus(1'b1, 5'b00011, 1'b0);
        checkOutput("b1_acc", 9'(acc4), 9'd3);
        checkOutput("b1_count", 9'(cnt4), 9'd1);
        checkOutput("b1_ready", 9'(ready4), 9'd1);
        applyStimulus(1'b1, 5'b00111, 1'b0);
        checkOutput("b2_acc", 9'(acc4), 9'd10);
        checkOutput("b2_count", 9'(cnt4), 9'd2);
        applyStimulus(1'b1, 5'b01111, 1'b0);
        checkOutput("b3_acc", 9'(acc4), 9'd25);
        checkOutput("b3_count", 9'(cnt4), 9'd3);
        checkOutput("b3_done", 9'(done4), 9'd0);
        applyStimulus(1'b1, 5'b10000, 1'b0);
        checkOutput("b4_acc", 9'(acc4), 9'd41);
        checkOutput("b4_count", 9'(cnt4), 9'd4);
        checkOutput("b4_done", 9'(done4), 9'd1);
        checkOutput("b4_ready", 9'(ready4), 9'd0);
        checkOutput("b4_ovf", 9'(ovf4), 9'd0);

        // HOLD ignores valid_in
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 5'b01111, 1'b0);
            checkOutput("hold_acc", 9'(acc4), 9'd41);
            checkOutput("hold_count", 9'(cnt4), 9'd4);
        end
        checkOutput("hold_done", 9'(done4), 9'd1);

        applyStimulus(1'b0, 5'd0, 1'b1);
        checkOutput("clr_acc", 9'(acc4), 9'd0);
        checkOutput("clr_count", 9'(cnt4), 9'd0);
        checkOutput("clr_done", 9'(done4), 9'd0);
        checkOutput("clr_ready", 9'(ready4), 9'd1);

        // Clear beats a simultaneous transfer in RUN
        applyStimulus(1'b1, 5'd3, 1'b0);
        applyStimulus(1'b1, 5'd7, 1'b0);
        checkOutput("run_acc", 9'(acc4), 9'd10);
        applyStimulus(1'b1, 5'd5, 1'b1);
        checkOutput("clrwin_acc", 9'(acc4), 9'd0);
        checkOutput("clrwin_count", 9'(cnt4), 9'd0);
        checkOutput("clrwin_ready", 9'(ready4), 9'd1);
        applyStimulus(1'b1, 5'd2, 1'b0);
        checkOutput("restart_acc", 9'(acc4), 9'd2);
        checkOutput("restart_count", 9'(cnt4), 9'd1);

        // Asynchronous reset between edges with count=2
        applyStimulus(1'b1, 5'd4, 1'b0);
        checkOutput("pre_arst_acc", 9'(acc4), 9'd6);
        checkOutput("pre_arst_count", 9'(cnt4), 9'd2);
        applyStimulus(1'b0, 5'd0, 1'b0);
        #2;
        reset = 1'b1;
        #1;
        checkOutput("arst_acc", 9'(acc4), 9'd0);
        checkOutput("arst_count", 9'(cnt4), 9'd0);
        checkOutput("arst_ready", 9'(ready4), 9'd1);
        #2;
        reset = 1'b0;

        // valid_in toggling: only 5, 6, 1, 8 are taken
        applyStimulus(1'b1, 5'd5, 1'b0);
        applyStimulus(1'b0, 5'd9, 1'b0);
        checkOutput("tog_acc1", 9'(acc4), 9'd5);
        checkOutput("tog_count1", 9'(cnt4), 9'd1);
        applyStimulus(1'b1, 5'd6, 1'b0);
        applyStimulus(1'b0, 5'd20, 1'b0);
        applyStimulus(1'b1, 5'd1, 1'b0);
        checkOutput("tog_acc3", 9'(acc4), 9'd12);
        checkOutput("tog_count3", 9'(cnt4), 9'd3);
        applyStimulus(1'b0, 5'd31, 1'b0);
        applyStimulus(1'b1, 5'd8, 1'b0);
        checkOutput("tog_acc4", 9'(acc4), 9'd20);
        checkOutput("tog_done4", 9'(done4), 9'd1);

        // Nine transfers of 31: N_OPS=8 stops at 248, N_OPS=9 crosses 255
        applyStimulus(1'b0, 5'd0, 1'b1);
        for (int i = 0; i < 8; i++) applyStimulus(1'b1, 5'd31, 1'b0);
        checkOutput("n4_acc", 9'(acc4), 9'd124);
        checkOutput("n8_acc", 9'(acc8), 9'd248);
        checkOutput("n8_ovf", 9'(ovf8), 9'd0);
        checkOutput("n8_done", 9'(done8), 9'd1);
        checkOutput("n9_acc8", 9'(acc9), 9'd248);
        checkOutput("n9_count8", 9'(cnt9), 9'd8);
        checkOutput("n9_ready8", 9'(ready9), 9'd1);
        checkOutput("n9_ovf8", 9'(ovf9), 9'd0);
        applyStimulus(1'b1, 5'd31, 1'b0);
        checkOutput("n8_hold_acc", 9'(acc8), 9'd248);
        checkOutput("n8_hold_count", 9'(cnt8), 9'd8);
        checkOutput("n9_acc", 9'(acc9), 9'(EXP_ACC9));
        checkOutput("n9_ovf", 9'(ovf9), 9'd1);
        checkOutput("n9_done", 9'(done9), 9'd1);
        checkOutput("n9_count", 9'(cnt9), 9'd9);
        applyStimulus(1'b0, 5'd0, 1'b0);
        checkOutput("n9_ovf_sticky", 9'(ovf9), 9'd1);
        applyStimulus(1'b0, 5'd0, 1'b1);
        checkOutput("n9_clr_ovf", 9'(ovf9), 9'd0);
        checkOutput("n9_clr_acc", 9'(acc9), 9'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
